alg_amba_vip_delay_stats_report: RTL and testbench
==================================================

Name: alg_amba_vip_delay_stats_report

Overview:
Downstream consumer of the AMBA VIP delay-statistics stage: on request it snapshots the running latency counters, optionally clears them, and computes the average latency (delay_total / nb_request) with a sequential restoring divider. It gives testbench monitors and scoreboards a coherent, stable report (average, remainder, min, max, error flags) without stalling statistics collection.

Parameters:
TOTAL_WIDTH, 64, width of delay_total input, snapshot and average quotient
NBREQ_WIDTH, 56, width of nb_request input, snapshot and remainder (must be <= TOTAL_WIDTH)
VALUE_WIDTH, 16, width of min/max per-request delay values

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
snap_req  input  1  request snapshot + average computation; accepted only when snap_busy=0
clear_on_snap  input  1  sampled with accepted snap_req; 1 = clear stats counters at capture
delay_total  input  TOTAL_WIDTH  running summed delay from stats stage
nb_request  input  NBREQ_WIDTH  running completed-request count from stats stage
max_value_req  input  VALUE_WIDTH  running max per-request delay
min_value_req  input  VALUE_WIDTH  running min per-request delay
err_in  input  4  {total_overflow, timer_overflow, fifo_full, nbreq_overflow} from stats stage
cnt_rst  output  1  counter clear to stats stage
snap_busy  output  1  snapshot/division in progress
snap_done  output  1  one-cycle pulse: report outputs valid and stable
snap_total  output  TOTAL_WIDTH  captured delay_total
snap_nbreq  output  NBREQ_WIDTH  captured nb_request
snap_max  output  VALUE_WIDTH  captured max
snap_min  output  VALUE_WIDTH  captured min (0 if snap_nbreq==0)
snap_err  output  4  captured err_in
avg_delay  output  TOTAL_WIDTH  truncated quotient snap_total / snap_nbreq
avg_rem  output  NBREQ_WIDTH  remainder
div_by_zero  output  1  captured nb_request was 0
snap_dropped  output  1  sticky: snap_req seen while busy

Behaviour:
- Reset (rstn=0, async): FSM to IDLE; all outputs 0; iteration counter and divider registers cleared. Reset during DIVIDE aborts with no snap_done and no cnt_rst.
- FSM states: IDLE, DIVIDE, DONE.
- IDLE: snap_busy=0. Accept = snap_req & state==IDLE. On the accepting edge capture all inputs into snap_* registers, clear snap_dropped, set div_by_zero=(nb_request==0). Next state DONE if nb_request==0, else DIVIDE with counter=TOTAL_WIDTH-1.
- cnt_rst is combinational: snap_req & state==IDLE & clear_on_snap. It is high in the accepting cycle only, so the stats stage clears on the same edge the snapshot is taken; no request is both reported and retained, and none is lost.
- DIVIDE: restoring division, one quotient bit per cycle, MSB first. Partial remainder is NBREQ_WIDTH+1 bits. Each cycle: shift in the next dividend bit; subtract divisor if the result is >= 0; set the quotient bit. Exactly TOTAL_WIDTH cycles; DONE follows the counter==0 iteration.
- DONE: one cycle; snap_done=1, snap_busy=1; avg_delay and avg_rem are final; next state IDLE.
- Latency (nonzero divisor): snap_req accepted in cycle 0; snap_busy=1 in cycles 1..TOTAL_WIDTH+1; snap_done in cycle TOTAL_WIDTH+1 (65 at default). Zero divisor: snap_done in cycle 1; avg_delay=0, avg_rem=0, snap_min=0.
- Back-to-back: snap_req may be accepted in the cycle after DONE (IDLE); there is no combinational acceptance during DONE.
- snap_req while snap_busy=1: ignored (not queued), cnt_rst not asserted, snap_dropped set to 1 and held until the next accepted snap_req.
- snap_* / avg_* / div_by_zero hold their values until the next accepted snap_req. avg_delay/avg_rem are undefined-to-observers (internal working values) while snap_busy=1 before snap_done; consumers sample on snap_done only.
- Input changes after capture (including stats counters continuing) do not affect the computation.
- Arithmetic: truncating unsigned division; avg_delay*snap_nbreq + avg_rem == snap_total with avg_rem < snap_nbreq.

Test Plan:
- delay_total=1000, nb_request=7, snap_req 1 cycle -> snap_done at cycle 65, avg_delay=142, avg_rem=6, div_by_zero=0, cnt_rst stays 0.
- nb_request=0, delay_total=55, min=16'hFFFF -> snap_done at cycle 1, avg_delay=0, avg_rem=0, div_by_zero=1, snap_min=0.
- clear_on_snap=1 with snap_req in IDLE -> cnt_rst=1 in that same cycle only; snap_total/snap_nbreq equal the pre-clear values; a second snap_req with clear -> snap_nbreq=0.
- delay_total=2^64-1, nb_request=1 -> avg_delay=2^64-1, avg_rem=0; delay_total=2^64-1, nb_request=2^56-1 -> avg_delay=256, avg_rem=255.
- snap_req pulsed at cycle 10 of DIVIDE -> ignored, cnt_rst=0, snap_dropped=1 until next accepted snap_req; first report unaffected.
- rstn low at cycle 30 of DIVIDE -> no snap_done, all outputs 0, FSM in IDLE; new snap_req after release completes normally.

Source files
------------

// File: rtl/alg_amba_vip_delay_stats_report_if.sv
// Report-side bundle between the delay-stats stage and the report block.
// The master drives the running counters and the request; the slave produces the report.
interface alg_amba_vip_delay_stats_report_if #(
  parameter int TOTAL_WIDTH = 64,
  parameter int NBREQ_WIDTH = 56,
  parameter int VALUE_WIDTH = 16
);
  logic                   snap_req;
  logic                   clear_on_snap;
  logic [TOTAL_WIDTH-1:0] delay_total;
  logic [NBREQ_WIDTH-1:0] nb_request;
  logic [VALUE_WIDTH-1:0] max_value_req;
  logic [VALUE_WIDTH-1:0] min_value_req;
  logic [3:0]             err_in;
  logic                   cnt_rst;
  logic                   snap_busy;
  logic                   snap_done;
  logic [TOTAL_WIDTH-1:0] snap_total;
  logic [NBREQ_WIDTH-1:0] snap_nbreq;
  logic [VALUE_WIDTH-1:0] snap_max;
  logic [VALUE_WIDTH-1:0] snap_min;
  logic [3:0]             snap_err;
  logic [TOTAL_WIDTH-1:0] avg_delay;
  logic [NBREQ_WIDTH-1:0] avg_rem;
  logic                   div_by_zero;
  logic                   snap_dropped;

  modport master (
    output snap_req, clear_on_snap, delay_total, nb_request,
           max_value_req, min_value_req, err_in,
    input  cnt_rst, snap_busy, snap_done, snap_total, snap_nbreq, snap_max,
           snap_min, snap_err, avg_delay, avg_rem, div_by_zero, snap_dropped
  );

  modport slave (
    input  snap_req, clear_on_snap, delay_total, nb_request,
           max_value_req, min_value_req, err_in,
    output cnt_rst, snap_busy, snap_done, snap_total, snap_nbreq, snap_max,
           snap_min, snap_err, avg_delay, avg_rem, div_by_zero, snap_dropped
  );
endinterface

// File: rtl/alg_amba_vip_delay_stats_report.sv
// Snapshots the running delay statistics on request and derives the average
// latency with a one-bit-per-cycle restoring divider.
module alg_amba_vip_delay_stats_report #(
  parameter int TOTAL_WIDTH = 64,
  parameter int NBREQ_WIDTH = 56,
  parameter int VALUE_WIDTH = 16
) (
  input  logic clk,
  input  logic rstn,
  alg_amba_vip_delay_stats_report_if.slave bus
);
  localparam int CW = (TOTAL_WIDTH > 1) ? $clog2(TOTAL_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_e;

  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [TOTAL_WIDTH-1:0] snap_total_q;
  logic [NBREQ_WIDTH-1:0] snap_nbreq_q;
  logic [VALUE_WIDTH-1:0] snap_max_q;
  logic [VALUE_WIDTH-1:0] snap_min_q;
  logic [3:0]             snap_err_q;
  logic [TOTAL_WIDTH-1:0] quot_q, quot_d;
  logic [NBREQ_WIDTH-1:0] rem_q, rem_d;
  logic                   dbz_q, dropped_q, busy_q, done_q;
  logic                   accept;

  // Partial remainder is one bit wider than the divisor so the trial compare never overflows.
  logic [NBREQ_WIDTH:0]   trial, diff;
  logic                   ge;

  assign accept = bus.snap_req && (state_q == IDLE);

  always_comb begin
    trial  = {rem_q, quot_q[TOTAL_WIDTH-1]};
    diff   = trial - {1'b0, snap_nbreq_q};
    ge     = (trial >= {1'b0, snap_nbreq_q});
    rem_d  = ge ? diff[NBREQ_WIDTH-1:0] : trial[NBREQ_WIDTH-1:0];
    quot_d = {quot_q[TOTAL_WIDTH-2:0], ge};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      snap_total_q <= '0;
      snap_nbreq_q <= '0;
      snap_max_q   <= '0;
      snap_min_q   <= '0;
      snap_err_q   <= '0;
      quot_q       <= '0;
      rem_q        <= '0;
      dbz_q        <= 1'b0;
      dropped_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      if (bus.snap_req && state_q != IDLE) dropped_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (accept) begin
            snap_total_q <= bus.delay_total;
            snap_nbreq_q <= bus.nb_request;
            snap_max_q   <= bus.max_value_req;
            snap_err_q   <= bus.err_in;
            dropped_q    <= 1'b0;
            busy_q       <= 1'b1;
            rem_q        <= '0;
            cnt_q        <= CW'(TOTAL_WIDTH - 1);
            if (bus.nb_request == '0) begin
              // Empty window: report zeros instead of a meaningless min and quotient.
              snap_min_q <= '0;
              quot_q     <= '0;
              dbz_q      <= 1'b1;
              done_q     <= 1'b1;
              state_q    <= DONE;
            end else begin
              snap_min_q <= bus.min_value_req;
              quot_q     <= bus.delay_total;
              dbz_q      <= 1'b0;
              state_q    <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          quot_q <= quot_d;
          rem_q  <= rem_d;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Counter clear shares the capture edge so no request is both reported and retained.
  assign bus.cnt_rst      = accept && bus.clear_on_snap;
  assign bus.snap_busy    = busy_q;
  assign bus.snap_done    = done_q;
  assign bus.snap_total   = snap_total_q;
  assign bus.snap_nbreq   = snap_nbreq_q;
  assign bus.snap_max     = snap_max_q;
  assign bus.snap_min     = snap_min_q;
  assign bus.snap_err     = snap_err_q;
  assign bus.avg_delay    = quot_q;
  assign bus.avg_rem      = rem_q;
  assign bus.div_by_zero  = dbz_q;
  assign bus.snap_dropped = dropped_q;
endmodule

// File: tb/tb_alg_amba_vip_delay_stats_report.sv
// Randomized and directed checks of the stats report block against a plain-arithmetic model.
module tb_alg_amba_vip_delay_stats_report;
  localparam int TW = 64;
  localparam int NW = 56;
  localparam int VW = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  alg_amba_vip_delay_stats_report_if #(.TOTAL_WIDTH(TW), .NBREQ_WIDTH(NW), .VALUE_WIDTH(VW)) bus();

  alg_amba_vip_delay_stats_report #(.TOTAL_WIDTH(TW), .NBREQ_WIDTH(NW), .VALUE_WIDTH(VW)) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.snap_req      = 1'b0;
    bus.clear_on_snap = 1'b0;
  endtask

  task automatic scramble();
    bus.delay_total   = {$urandom, $urandom};
    bus.nb_request    = NW'({$urandom, $urandom});
    bus.max_value_req = VW'($urandom);
    bus.min_value_req = VW'($urandom);
    bus.err_in        = 4'($urandom);
  endtask

  // Issue a snapshot from IDLE, wait for the report and compare it against
  // the truncating division of the captured values.
  task automatic run_snap(input logic [TW-1:0] tot, input logic [NW-1:0] nb,
                          input logic [VW-1:0] mx, input logic [VW-1:0] mn,
                          input logic [3:0] er, input bit clr, input bit scr,
                          input string tag);
    int lat;
    logic [TW-1:0] e_avg, e_rem;
    @(posedge clk); #1;
    bus.delay_total = tot; bus.nb_request = nb;
    bus.max_value_req = mx; bus.min_value_req = mn; bus.err_in = er;
    bus.clear_on_snap = clr; bus.snap_req = 1'b1;
    #1 chk({tag, ".cnt_rst"}, 64'(bus.cnt_rst), 64'(clr));
    @(posedge clk); #1;
    drive_idle();
    if (scr) scramble();
    lat = 1;
    while (!bus.snap_done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      chk({tag, ".cnt_rst_busy"}, 64'(bus.cnt_rst), 64'd0);
    end
    chk({tag, ".timeout"}, 64'(lat < 200), 64'd1);
    e_avg = (nb == 0) ? '0 : tot / {8'd0, nb};
    e_rem = (nb == 0) ? '0 : tot % {8'd0, nb};
    chk({tag, ".latency"}, 64'(lat), (nb == 0) ? 64'd1 : 64'(TW + 1));
    chk({tag, ".busy_at_done"}, 64'(bus.snap_busy), 64'd1);
    chk({tag, ".avg"}, bus.avg_delay, e_avg);
    chk({tag, ".rem"}, 64'(bus.avg_rem), e_rem);
    chk({tag, ".total"}, bus.snap_total, tot);
    chk({tag, ".nbreq"}, 64'(bus.snap_nbreq), 64'(nb));
    chk({tag, ".max"}, 64'(bus.snap_max), 64'(mx));
    chk({tag, ".min"}, 64'(bus.snap_min), (nb == 0) ? 64'd0 : 64'(mn));
    chk({tag, ".err"}, 64'(bus.snap_err), 64'(er));
    chk({tag, ".dbz"}, 64'(bus.div_by_zero), 64'(nb == 0));
    @(posedge clk); #1;
    chk({tag, ".idle_busy"}, 64'(bus.snap_busy), 64'd0);
    chk({tag, ".done_pulse"}, 64'(bus.snap_done), 64'd0);
    chk({tag, ".hold_avg"}, bus.avg_delay, e_avg);
  endtask

  initial begin
    logic [TW-1:0] all1;
    logic [NW-1:0] nb_all1;
    logic [NW-1:0] rnb;
    int lat;
    all1 = '1;
    nb_all1 = '1;
    drive_idle();
    scramble();

    // Reset state
    #12;
    chk("rst.busy", 64'(bus.snap_busy), 64'd0);
    chk("rst.done", 64'(bus.snap_done), 64'd0);
    chk("rst.avg", bus.avg_delay, 64'd0);
    chk("rst.total", bus.snap_total, 64'd0);
    chk("rst.dropped", 64'(bus.snap_dropped), 64'd0);
    chk("rst.dbz", 64'(bus.div_by_zero), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    run_snap(64'd1000, 56'd7, 16'd90, 16'd3, 4'h0, 1'b0, 1'b0, "d1000_7");
    run_snap(64'd55, 56'd0, 16'd9, 16'hFFFF, 4'h5, 1'b0, 1'b0, "zero_div");

    // Clear on snap: the stats stage zeroes its counters on the accepting edge
    run_snap(64'd500, 56'd20, 16'd40, 16'd10, 4'h2, 1'b1, 1'b0, "clr1");
    run_snap(64'd0, 56'd0, 16'd0, 16'd0, 4'h0, 1'b1, 1'b0, "clr2");

    run_snap(all1, 56'd1, 16'd1, 16'd1, 4'h8, 1'b0, 1'b0, "max_by1");
    run_snap(all1, nb_all1, 16'd2, 16'd1, 4'hF, 1'b0, 1'b0, "max_bymax");

    // Request during DIVIDE must be dropped and flagged, not queued
    @(posedge clk); #1;
    bus.delay_total = 64'd1000; bus.nb_request = 56'd7;
    bus.max_value_req = 16'd5; bus.min_value_req = 16'd1; bus.err_in = 4'h0;
    bus.snap_req = 1'b1;
    @(posedge clk); #1;
    drive_idle();
    repeat (9) @(posedge clk);
    #1;
    bus.snap_req = 1'b1; bus.clear_on_snap = 1'b1;
    #1 chk("drop.cnt_rst", 64'(bus.cnt_rst), 64'd0);
    @(posedge clk); #1;
    drive_idle();
    chk("drop.flag", 64'(bus.snap_dropped), 64'd1);
    lat = 11;
    while (!bus.snap_done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("drop.latency", 64'(lat), 64'(TW + 1));
    chk("drop.avg", bus.avg_delay, 64'd142);
    chk("drop.rem", 64'(bus.avg_rem), 64'd6);
    chk("drop.flag_held", 64'(bus.snap_dropped), 64'd1);
    @(posedge clk); #1;
    bus.nb_request = 56'd3; bus.delay_total = 64'd10;
    bus.snap_req = 1'b1;
    @(posedge clk); #1;
    drive_idle();
    chk("drop.cleared", 64'(bus.snap_dropped), 64'd0);
    repeat (TW + 2) @(posedge clk);

    // Reset in the middle of the division aborts the report
    @(posedge clk); #1;
    bus.delay_total = 64'd777; bus.nb_request = 56'd5; bus.snap_req = 1'b1;
    @(posedge clk); #1;
    drive_idle();
    repeat (29) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("arst.busy", 64'(bus.snap_busy), 64'd0);
    chk("arst.done", 64'(bus.snap_done), 64'd0);
    chk("arst.avg", bus.avg_delay, 64'd0);
    chk("arst.rem", 64'(bus.avg_rem), 64'd0);
    chk("arst.total", bus.snap_total, 64'd0);
    chk("arst.nbreq", 64'(bus.snap_nbreq), 64'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    lat = 0;
    repeat (TW + 4) begin
      @(posedge clk); #1;
      if (bus.snap_done || bus.snap_busy) lat++;
    end
    chk("arst.quiet", 64'(lat), 64'd0);
    run_snap(64'd777, 56'd5, 16'd8, 16'd2, 4'h1, 1'b0, 1'b0, "arst.after");

    // Random vectors, with the stats inputs churning during the division
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0:       rnb = '0;
        1:       rnb = NW'($urandom_range(1, 300));
        default: rnb = NW'({$urandom, $urandom});
      endcase
      run_snap({$urandom, $urandom}, rnb, VW'($urandom), VW'($urandom),
               4'($urandom), 1'($urandom), 1'b1, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
